// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache memory arbiter.
// Holds the arbiter FSM states, grant-owner encoding and a tie-break helper.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Encoding is visible on the debug owner port: 0 none, 1 I-cache, 2 D-cache.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_D) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Winner selection between the I-cache and D-cache requests.
// ARB_RR_EN defined: ties alternate away from last_grant; otherwise D-cache wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_e last_grant_i,
    output owner_e winner_o
);

    always_comb begin
        winner_o = OWN_NONE;
        if (i_req_i && d_req_i) begin
`ifdef ARB_RR_EN
            winner_o = other_owner(last_grant_i);
`else
            // Data misses stall the pipeline harder than fetch, so D goes first.
            winner_o = OWN_D;
`endif
        end else if (i_req_i) begin
            winner_o = OWN_I;
        end else if (d_req_i) begin
            winner_o = OWN_D;
        end
    end

`ifndef ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_i;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port line memory arbiter shared by the I-cache (read) and D-cache (read/write).
// Tie policy selected by ARB_RR_EN (round-robin) vs. default fixed D-cache priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner
);

    state_e            state_q,      state_d;
    owner_e            owner_q,      owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q,    i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,    d_rdata_d;
    logic              i_ready_q,    i_ready_d;
    logic              d_ready_q,    d_ready_d;
    owner_e            winner;

    mem_arb_pick u_pick (
        .i_req_i      (i_read),
        .d_req_i      (d_read | d_write),
        .last_grant_i (last_grant_q),
        .winner_o     (winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (winner == OWN_I) begin
                    owner_d      = OWN_I;
                    last_grant_d = OWN_I;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = i_addr;
                    state_d      = ST_BUSY;
                end else if (winner == OWN_D) begin
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                    // A simultaneous read+write request is served as the write-back.
                    mem_write_d  = d_write;
                    mem_read_d   = d_read & ~d_write;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    owner_d     = OWN_NONE;
                    state_d     = ST_RESP;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        if (mem_read_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_ready_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                // Bubble: the served cache is still dropping its request this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            last_grant_q <= OWN_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (fixed priority or ARB_RR_EN build).
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [1:0]        owner;

    int errors = 0;
    int checks = 0;

    localparam logic [LINE_W-1:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [LINE_W-1:0] LINE_B = 128'h11111111_22222222_33333333_44444444;
    localparam logic [LINE_W-1:0] LINE_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .owner     (owner)
    );

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
        tick(); tick();
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: rd/wr/ir/dr=%b expected 0000", {mem_read, mem_write, i_ready, d_ready});
        end
        checks++;
        if (owner !== 2'd0) begin
            errors++; $display("FAIL reset_owner: got %0d expected 0", owner);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_data: i_rdata=%h d_rdata=%h mem_addr=%h expected zeros", i_rdata, d_rdata, mem_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_only();
        i_read = 1; i_addr = 28'h0000010;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010 || owner !== 2'd1) begin
            errors++; $display("FAIL i_issue: rd=%b wr=%b addr=%h owner=%0d expected 1 0 0000010 1", mem_read, mem_write, mem_addr, owner);
        end
        for (int k = 0; k < 3; k++) begin
            i_read = (k == 0);  // withdrawal while busy must not abort
            tick();
            checks++;
            if (mem_read !== 1'b1 || i_ready !== 1'b0 || mem_addr !== 28'h0000010) begin
                errors++; $display("FAIL i_hold: cycle %0d rd=%b ready=%b addr=%h expected 1 0 0000010", k, mem_read, i_ready, mem_addr);
            end
        end
        mem_ready = 1; mem_rdata = LINE_A;
        tick();
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== LINE_A || mem_read !== 1'b0 || d_ready !== 1'b0) begin
            errors++; $display("FAIL i_done: ready=%b rdata=%h rd=%b d_ready=%b expected 1 %h 0 0", i_ready, i_rdata, mem_read, d_ready, LINE_A);
        end
        mem_ready = 0; mem_rdata = LINE_C;
        tick();
        checks++;
        if (i_ready !== 1'b0 || i_rdata !== LINE_A || d_ready !== 1'b0) begin
            errors++; $display("FAIL i_pulse_end: ready=%b rdata=%h expected 0 %h", i_ready, i_rdata, LINE_A);
        end
        tick();
    endtask

    task automatic test_d_write();
        d_write = 1; d_addr = 28'h0000020; d_wdata = 128'h1;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000020 || mem_wdata !== 128'h1 || owner !== 2'd2) begin
            errors++; $display("FAIL d_issue: wr=%b rd=%b addr=%h wdata=%h owner=%0d expected 1 0 0000020 1 2", mem_write, mem_read, mem_addr, mem_wdata, owner);
        end
        d_addr = 28'h0BADBAD; d_wdata = LINE_C;  // changes while busy must not leak
        tick(); tick();
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 28'h0000020 || mem_wdata !== 128'h1 || d_ready !== 1'b0) begin
            errors++; $display("FAIL d_stable: wr=%b addr=%h wdata=%h ready=%b expected 1 0000020 1 0", mem_write, mem_addr, mem_wdata, d_ready);
        end
        mem_ready = 1; mem_rdata = LINE_B;
        tick();
        checks++;
        if (d_ready !== 1'b1 || mem_write !== 1'b0 || d_rdata !== '0 || i_ready !== 1'b0) begin
            errors++; $display("FAIL d_done: ready=%b wr=%b d_rdata=%h i_ready=%b expected 1 0 0 0", d_ready, mem_write, d_rdata, i_ready);
        end
        mem_ready = 0; d_write = 0;
        tick();
        checks++;
        if (d_ready !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL d_pulse_end: ready=%b owner=%0d expected 0 0", d_ready, owner);
        end
        tick();
    endtask

    task automatic test_rw_both();
        d_read = 1; d_write = 1; d_addr = 28'h0000024; d_wdata = LINE_C;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== LINE_C) begin
            errors++; $display("FAIL rw_as_write: wr=%b rd=%b wdata=%h expected 1 0 %h", mem_write, mem_read, mem_wdata, LINE_C);
        end
        mem_ready = 1; mem_rdata = LINE_A;
        tick();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== '0) begin
            errors++; $display("FAIL rw_rdata: ready=%b d_rdata=%h expected 1 0", d_ready, d_rdata);
        end
        mem_ready = 0; d_read = 0; d_write = 0;
        tick(); tick();
    endtask

    task automatic test_tie_fixed();
        pulse_reset();
        i_read = 1; i_addr = 28'h0000030; d_read = 1; d_addr = 28'h0000040;
        tick();
        checks++;
        if (owner !== 2'd2 || mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
            errors++; $display("FAIL tie_first: owner=%0d rd=%b addr=%h expected 2 1 0000040", owner, mem_read, mem_addr);
        end
        mem_ready = 1; mem_rdata = LINE_B;
        tick();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== LINE_B || i_ready !== 1'b0) begin
            errors++; $display("FAIL tie_d_done: d_ready=%b d_rdata=%h i_ready=%b expected 1 %h 0", d_ready, d_rdata, i_ready, LINE_B);
        end
        mem_ready = 0; d_read = 0;
        tick();
        checks++;
        if (mem_read !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL tie_bubble: rd=%b owner=%0d expected 0 0", mem_read, owner);
        end
        tick();
        checks++;
        if (owner !== 2'd1 || mem_read !== 1'b1 || mem_addr !== 28'h0000030) begin
            errors++; $display("FAIL tie_second: owner=%0d rd=%b addr=%h expected 1 1 0000030", owner, mem_read, mem_addr);
        end
        mem_ready = 1; mem_rdata = LINE_C;
        tick();
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== LINE_C || d_rdata !== LINE_B) begin
            errors++; $display("FAIL tie_i_done: i_ready=%b i_rdata=%h d_rdata=%h expected 1 %h %h", i_ready, i_rdata, d_rdata, LINE_C, LINE_B);
        end
        mem_ready = 0; i_read = 0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_own [3];
`ifdef ARB_RR_EN
        exp_own = '{2'd2, 2'd1, 2'd2};
`else
        exp_own = '{2'd2, 2'd2, 2'd2};
`endif
        pulse_reset();
        i_read = 1; i_addr = 28'h0000050; d_read = 1; d_addr = 28'h0000060;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (owner !== exp_own[t] || mem_read !== 1'b1) begin
                errors++; $display("FAIL b2b_grant%0d: owner=%0d rd=%b expected %0d 1", t, owner, mem_read, exp_own[t]);
            end
            mem_ready = 1;
            tick();
            mem_ready = 0;
            tick();
        end
        i_read = 0; d_read = 0;
        tick();
        checks++;
        if (owner !== 2'd0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: owner=%0d rd=%b expected 0 0", owner, mem_read);
        end
    endtask

    task automatic test_held_request();
        d_read = 1; d_addr = 28'h0000070;
        tick();
        mem_ready = 1; mem_rdata = LINE_A;
        tick();
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== LINE_A) begin
            errors++; $display("FAIL held_done: ready=%b rdata=%h expected 1 %h", d_ready, d_rdata, LINE_A);
        end
        mem_ready = 0;  // d_read still high through the bubble cycle
        tick();
        checks++;
        if (mem_read !== 1'b0 || d_ready !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL held_bubble: rd=%b ready=%b owner=%0d expected 0 0 0", mem_read, d_ready, owner);
        end
        d_read = 0;
        tick();
        checks++;
        if (mem_read !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL held_no_dup: rd=%b owner=%0d expected 0 0", mem_read, owner);
        end
        d_read = 1; d_addr = 28'h0000074;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000074 || owner !== 2'd2) begin
            errors++; $display("FAIL held_reissue: rd=%b addr=%h owner=%0d expected 1 0000074 2", mem_read, mem_addr, owner);
        end
        mem_ready = 1; mem_rdata = LINE_B;
        tick();
        mem_ready = 0; d_read = 0;
        tick(); tick();
    endtask

    task automatic test_reset_busy();
        i_read = 1; i_addr = 28'h0000080;
        tick();
        checks++;
        if (mem_read !== 1'b1) begin
            errors++; $display("FAIL rb_issue: rd=%b expected 1", mem_read);
        end
        tick();
        rst = 1;
        tick();
        checks++;
        if (mem_read !== 1'b0 || owner !== 2'd0 || i_ready !== 1'b0) begin
            errors++; $display("FAIL rb_abort: rd=%b owner=%0d ready=%b expected 0 0 0", mem_read, owner, i_ready);
        end
        rst = 0; i_read = 0; mem_ready = 1; mem_rdata = LINE_C;
        tick();
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== '0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL rb_late_ack: i_ready=%b d_ready=%b i_rdata=%h rd=%b expected 0 0 0 0", i_ready, d_ready, i_rdata, mem_read);
        end
        mem_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_write();
        test_rw_both();
        test_tie_fixed();
        test_back_to_back();
        test_held_request();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
